// File: rtl/chip8_cycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : chip8_cycle_sequencer
//  Purpose  : Chip-8 fetch/latch/execute sequencer with keypress stall and
//             60 Hz timer tick generation.
//  Revision : 1.0 - initial release
// ============================================================================
module chip8_cycle_sequencer #(
  parameter int EXEC_STAGES = 6,
  parameter int TICK_DIV    = 833333
) (
  input  logic        cpu_clk,
  input  logic        reset,
  input  logic        run,
  input  logic [11:0] PC_readdata,
  input  logic [7:0]  mem_readdata1,
  input  logic [7:0]  mem_readdata2,
  input  logic        halt_for_keypress,
  input  logic        key_pressed,
  output logic        fetch_active,
  output logic [11:0] fetch_addr1,
  output logic [11:0] fetch_addr2,
  output logic [15:0] instruction,
  output logic [31:0] stage,
  output logic        instr_done,
  output logic        timer_tick,
  output logic [31:0] instr_count
);

  localparam int              DIV_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX    = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
  localparam logic [31:0]      LAST_STAGE = 32'(EXEC_STAGES + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_LATCH   = 3'd2,
    S_EXEC    = 3'd3,
    S_KEYWAIT = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       stage_q, stage_d;
  logic [15:0]       instr_q, instr_d;
  logic [31:0]       count_q, count_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              w_last;
  logic              w_tick_en;

  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      stage_q <= 32'd0;
      instr_q <= 16'h0000;
      count_q <= 32'd0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      instr_q <= instr_d;
      count_q <= count_d;
      div_q   <= div_d;
    end
  end

  assign w_last    = (state_q == S_EXEC) && (stage_q == LAST_STAGE);
  assign w_tick_en = run || (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    instr_d = instr_q;
    count_d = count_q;
    div_d   = div_q;

    case (state_q)
      S_IDLE: begin
        stage_d = 32'd0;
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_LATCH;
        stage_d = 32'd1;
      end
      S_LATCH: begin
        state_d = S_EXEC;
        stage_d = 32'd2;
        instr_d = {mem_readdata1, mem_readdata2};
      end
      S_EXEC: begin
        // Completion wins over a stall request on the final stage so the
        // stage counter can never run past the execute window.
        if (w_last) begin
          count_d = count_q + 32'd1;
          stage_d = 32'd0;
          state_d = run ? S_FETCH : S_IDLE;
        end else if (halt_for_keypress && !key_pressed) begin
          state_d = S_KEYWAIT;
        end else begin
          stage_d = stage_q + 32'd1;
        end
      end
      S_KEYWAIT: begin
        if (key_pressed) begin
          state_d = S_EXEC;
          stage_d = stage_q + 32'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        stage_d = 32'd0;
      end
    endcase

    if (w_tick_en) begin
      div_d = (div_q == DIV_MAX) ? '0 : div_q + DIV_ONE;
    end
  end

  // Memory has one cycle of read latency, so addresses live only in FETCH
  // and the returned bytes are captured at the end of LATCH.
  assign fetch_active = (state_q == S_FETCH);
  assign fetch_addr1  = fetch_active ? PC_readdata : 12'h000;
  assign fetch_addr2  = fetch_active ? (PC_readdata + 12'h001) : 12'h000;
  assign instruction  = instr_q;
  assign stage        = stage_q;
  assign instr_done   = w_last;
  assign timer_tick   = w_tick_en && (div_q == DIV_MAX);
  assign instr_count  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_chip8_cycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_chip8_cycle_sequencer
//  Purpose  : Scoreboard bench for the Chip-8 cycle sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_chip8_cycle_sequencer;

  logic        cpu_clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [11:0] pc = 12'h000;
  logic [7:0]  rd1, rd2;
  logic        halt = 1'b0;
  logic        key = 1'b0;
  logic        fetch_active;
  logic [11:0] fetch_addr1, fetch_addr2;
  logic [15:0] instruction;
  logic [31:0] stage;
  logic        instr_done;
  logic        timer_tick;
  logic [31:0] instr_count;

  logic [7:0]  mem [0:4095];
  logic [15:0] exp_q [$];
  int          n_vec = 0;
  int          n_miss = 0;
  int          exp_count = 0;

  chip8_cycle_sequencer #(.EXEC_STAGES(6), .TICK_DIV(5)) dut (
    .cpu_clk           (cpu_clk),
    .reset             (reset),
    .run               (run),
    .PC_readdata       (pc),
    .mem_readdata1     (rd1),
    .mem_readdata2     (rd2),
    .halt_for_keypress (halt),
    .key_pressed       (key),
    .fetch_active      (fetch_active),
    .fetch_addr1       (fetch_addr1),
    .fetch_addr2       (fetch_addr2),
    .instruction       (instruction),
    .stage             (stage),
    .instr_done        (instr_done),
    .timer_tick        (timer_tick),
    .instr_count       (instr_count)
  );

  always #5 cpu_clk = ~cpu_clk;

  always @(posedge cpu_clk) begin
    rd1 <= mem[fetch_addr1];
    rd2 <= mem[fetch_addr2];
  end

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic wait_done(input int budget, output int edges, output bit ok);
    edges = 0;
    ok = 1'b0;
    while (edges < budget && !ok) begin
      step();
      edges++;
      if (instr_done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if ({stage, instruction, fetch_active, fetch_addr1, fetch_addr2, instr_done, timer_tick, instr_count} !==
        {32'd0, 16'h0000, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 32'd0}) begin
      n_miss++;
      $display("FAIL reset_async: stage=%0d instr=%h fa=%b a1=%h a2=%h done=%b tick=%b cnt=%0d want all zero",
               stage, instruction, fetch_active, fetch_addr1, fetch_addr2, instr_done, timer_tick, instr_count);
    end
    run = 1'b1;
    step();
    step();
    n_vec++;
    if (fetch_active !== 1'b0 || stage !== 32'd0) begin
      n_miss++;
      $display("FAIL reset_hold: fetch_active=%b stage=%0d want 0/0", fetch_active, stage);
    end
    run = 1'b0;
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [15:0] e;
    pc = 12'h200;
    exp_q.push_back(16'h61F0);
    run = 1'b1;
    step();
    n_vec++;
    if ({fetch_active, fetch_addr1, fetch_addr2, stage} !== {1'b1, 12'h200, 12'h201, 32'd0}) begin
      n_miss++;
      $display("FAIL basic_fetch: fa=%b a1=%h a2=%h stage=%0d want 1 200 201 0",
               fetch_active, fetch_addr1, fetch_addr2, stage);
    end
    step();
    n_vec++;
    if ({fetch_active, fetch_addr1, fetch_addr2, stage} !== {1'b0, 12'h000, 12'h000, 32'd1}) begin
      n_miss++;
      $display("FAIL basic_latch: fa=%b a1=%h a2=%h stage=%0d want 0 000 000 1",
               fetch_active, fetch_addr1, fetch_addr2, stage);
    end
    for (int s = 2; s <= 7; s++) begin
      step();
      n_vec++;
      if (stage !== 32'(s) || instr_done !== (s == 7)) begin
        n_miss++;
        $display("FAIL basic_stage: stage=%0d done=%b want stage %0d done %b", stage, instr_done, s, (s == 7));
      end
      if (s == 2) begin
        n_vec++;
        if (instruction !== 16'h61F0) begin
          n_miss++;
          $display("FAIL basic_instr_early: got %h want 61F0", instruction);
        end
      end
    end
    n_vec++;
    if (exp_q.size() == 0) begin
      n_miss++;
      $display("FAIL basic_sb: scoreboard empty, got %h", instruction);
    end else begin
      e = exp_q.pop_front();
      if (instruction !== e) begin
        n_miss++;
        $display("FAIL basic_sb: got %h want %h", instruction, e);
      end
    end
    run = 1'b0;
    step();
    exp_count++;
    n_vec++;
    if (instr_count !== 32'(exp_count) || stage !== 32'd0) begin
      n_miss++;
      $display("FAIL basic_count: cnt=%0d stage=%0d want %0d 0", instr_count, stage, exp_count);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] e;
    int edges;
    bit ok;
    pc = 12'hFFF;
    exp_q.push_back(16'hA23C);
    run = 1'b1;
    step();
    n_vec++;
    if ({fetch_addr1, fetch_addr2} !== {12'hFFF, 12'h000}) begin
      n_miss++;
      $display("FAIL wrap_addr: a1=%h a2=%h want FFF 000", fetch_addr1, fetch_addr2);
    end
    wait_done(20, edges, ok);
    n_vec++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    if (!ok || instruction !== e) begin
      n_miss++;
      $display("FAIL wrap_sb: done=%b got %h want %h", ok, instruction, e);
    end
    run = 1'b0;
    step();
    exp_count++;
  endtask

  task automatic test_keywait();
    logic [15:0] e;
    int c;
    int edges;
    bit ok;
    pc = 12'h300;
    exp_q.push_back(16'hF10A);
    run = 1'b1;
    c = 0;
    for (int i = 0; i < 10 && stage !== 32'd3; i++) begin
      step();
      c++;
    end
    n_vec++;
    if (stage !== 32'd3) begin
      n_miss++;
      $display("FAIL kw_reach: stage=%0d want 3", stage);
    end
    halt = 1'b1;
    key = 1'b0;
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      c++;
      n_vec++;
      if (stage !== 32'd3 || instr_done !== 1'b0) begin
        n_miss++;
        $display("FAIL kw_hold: cycle %0d stage=%0d done=%b want 3 0", i, stage, instr_done);
      end
    end
    key = 1'b1;
    step();
    c++;
    n_vec++;
    if (stage !== 32'd4) begin
      n_miss++;
      $display("FAIL kw_release: stage=%0d want 4", stage);
    end
    halt = 1'b0;
    key = 1'b0;
    wait_done(20, edges, ok);
    c += edges;
    n_vec++;
    if (!ok || c != 18) begin
      n_miss++;
      $display("FAIL kw_period: done=%b cycles=%0d want 18", ok, c);
    end
    n_vec++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    if (instruction !== e) begin
      n_miss++;
      $display("FAIL kw_sb: got %h want %h", instruction, e);
    end
    step();
    exp_count++;
    n_vec++;
    if (stage !== 32'd0 || fetch_active !== 1'b0 || instr_count !== 32'(exp_count)) begin
      n_miss++;
      $display("FAIL kw_idle: stage=%0d fa=%b cnt=%0d want 0 0 %0d", stage, fetch_active, instr_count, exp_count);
    end
  endtask

  task automatic test_simultaneous();
    logic [15:0] e;
    int c;
    int edges;
    bit ok;
    pc = 12'h400;
    exp_q.push_back(16'hE59E);
    run = 1'b1;
    c = 0;
    for (int i = 0; i < 10 && stage !== 32'd3; i++) begin
      step();
      c++;
    end
    halt = 1'b1;
    key = 1'b1;
    run = 1'b0;
    wait_done(20, edges, ok);
    c += edges;
    n_vec++;
    if (!ok || c != 8) begin
      n_miss++;
      $display("FAIL simul_period: done=%b cycles=%0d want 8", ok, c);
    end
    n_vec++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    if (instruction !== e) begin
      n_miss++;
      $display("FAIL simul_sb: got %h want %h", instruction, e);
    end
    halt = 1'b0;
    key = 1'b0;
    step();
    exp_count++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    int edges;
    bit ok;
    pc = 12'h500;
    exp_q.push_back(16'h1234);
    run = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_done(20, edges, ok);
      n_vec++;
      if (!ok || edges != 8) begin
        n_miss++;
        $display("FAIL b2b_period: instr %0d done=%b cycles=%0d want 8", k, ok, edges);
      end
      n_vec++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
      if (instruction !== e) begin
        n_miss++;
        $display("FAIL b2b_sb: instr %0d got %h want %h", k, instruction, e);
      end
      if (k == 0) begin
        pc = 12'h502;
        exp_q.push_back(16'h5678);
      end
    end
    run = 1'b0;
    step();
    exp_count += 2;
    n_vec++;
    if (instr_count !== 32'(exp_count)) begin
      n_miss++;
      $display("FAIL b2b_count: cnt=%0d want %0d", instr_count, exp_count);
    end
  endtask

  task automatic test_drop_run();
    logic [15:0] e;
    int edges;
    bit ok;
    pc = 12'h600;
    exp_q.push_back(16'h00E0);
    run = 1'b1;
    for (int i = 0; i < 10 && stage !== 32'd4; i++) step();
    run = 1'b0;
    wait_done(20, edges, ok);
    n_vec++;
    if (!ok || edges != 3) begin
      n_miss++;
      $display("FAIL drop_complete: done=%b cycles=%0d want 3", ok, edges);
    end
    n_vec++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    if (instruction !== e) begin
      n_miss++;
      $display("FAIL drop_sb: got %h want %h", instruction, e);
    end
    exp_count++;
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++;
      if (stage !== 32'd0 || fetch_active !== 1'b0 || instruction !== 16'h00E0) begin
        n_miss++;
        $display("FAIL drop_idle: stage=%0d fa=%b instr=%h want 0 0 00E0", stage, fetch_active, instruction);
      end
    end
    n_vec++;
    if (instr_count !== 32'(exp_count)) begin
      n_miss++;
      $display("FAIL drop_count: cnt=%0d want %0d", instr_count, exp_count);
    end
  endtask

  task automatic test_timer_reset();
    logic [15:0] e;
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    exp_count = 0;
    pc = 12'h200;
    exp_q.push_back(16'h61F0);
    run = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      step();
      n_vec++;
      if (timer_tick !== (c % 5 == 4)) begin
        n_miss++;
        $display("FAIL tick_run: cycle %0d tick=%b want %b", c + 1, timer_tick, (c % 5 == 4));
      end
      if (instr_done === 1'b1) begin
        n_vec++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        if (instruction !== e) begin
          n_miss++;
          $display("FAIL tick_sb: got %h want %h", instruction, e);
        end
      end
    end
    n_vec++;
    if (instr_count !== 32'd1) begin
      n_miss++;
      $display("FAIL tick_precount: cnt=%0d want 1", instr_count);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if ({instr_count, stage, instruction, fetch_active, instr_done, timer_tick} !==
        {32'd0, 32'd0, 16'h0000, 1'b0, 1'b0, 1'b0}) begin
      n_miss++;
      $display("FAIL reset_mid: cnt=%0d stage=%0d instr=%h fa=%b done=%b tick=%b want zeros",
               instr_count, stage, instruction, fetch_active, instr_done, timer_tick);
    end
    step();
    reset = 1'b0;
    exp_q.delete();
    for (int c = 1; c <= 10; c++) begin
      step();
      n_vec++;
      if (timer_tick !== (c % 5 == 4)) begin
        n_miss++;
        $display("FAIL tick_restart: cycle %0d tick=%b want %b", c + 1, timer_tick, (c % 5 == 4));
      end
    end
    run = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i ^ (i >> 4));
    mem[12'h200] = 8'h61; mem[12'h201] = 8'hF0;
    mem[12'hFFF] = 8'hA2; mem[12'h000] = 8'h3C;
    mem[12'h300] = 8'hF1; mem[12'h301] = 8'h0A;
    mem[12'h400] = 8'hE5; mem[12'h401] = 8'h9E;
    mem[12'h500] = 8'h12; mem[12'h501] = 8'h34;
    mem[12'h502] = 8'h56; mem[12'h503] = 8'h78;
    mem[12'h600] = 8'h00; mem[12'h601] = 8'hE0;

    test_reset();
    test_basic();
    test_wrap();
    test_keywait();
    test_simultaneous();
    test_back_to_back();
    test_drop_run();
    test_timer_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/chip8_cycle_sequencer.md
Name: chip8_cycle_sequencer

Overview:
- Drives the Chip-8 CPU instruction cycle: fetches the two instruction bytes at PC, presents the `instruction` word and the `stage` counter to Chip8_CPU, and runs the fixed execute window.
- Freezes execution while the CPU waits for a keypress (Fx0A).
- Generates the 60 Hz timer tick for the delay/sound timers.
- Sits between the top-level run control, main memory read ports and Chip8_CPU.

Parameters:
- EXEC_STAGES, 6: number of execute cycles per instruction; the CPU sees stages 2..EXEC_STAGES+1.
- TICK_DIV, 833333: cpu_clk cycles per timer tick (50 MHz / 60 Hz).

Ports:
- cpu_clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  host enable; level-sensitive.
- PC_readdata  in  12  current program counter from the CPU.
- mem_readdata1  in  8  memory byte at fetch_addr1; 1-cycle read latency.
- mem_readdata2  in  8  memory byte at fetch_addr2; 1-cycle read latency.
- halt_for_keypress  in  1  CPU request to stall until a key is pressed.
- key_pressed  in  1  keypad has a valid key.
- fetch_active  out  1  high while the sequencer owns memory ports 1/2.
- fetch_addr1  out  12  high-byte fetch address.
- fetch_addr2  out  12  low-byte fetch address.
- instruction  out  16  latched opcode to the CPU.
- stage  out  32  per-instruction stage counter to the CPU.
- instr_done  out  1  one-cycle pulse on the last execute stage.
- timer_tick  out  1  one-cycle pulse every TICK_DIV cycles while running.
- instr_count  out  32  count of completed instructions; wraps.

Behaviour:
- Reset values (asynchronous, while reset=1): state=IDLE, stage=0, instruction=16'h0000, fetch_active=0, fetch_addr1=fetch_addr2=0, instr_done=0, timer_tick=0, instr_count=0, tick divider=0.
- IDLE:
  - stage=0; fetch outputs 0.
  - run=1 → FETCH on the next edge.
- FETCH (1 cycle):
  - stage=0, fetch_active=1, fetch_addr1=PC_readdata, fetch_addr2=(PC_readdata+1) mod 4096 (0xFFF wraps to 0x000).
  - → LATCH.
- LATCH (1 cycle):
  - stage=1, fetch_active=0, fetch addresses return to 0.
  - At the end of the cycle, instruction <= {mem_readdata1, mem_readdata2}.
  - → EXEC.
- instruction is held stable from LATCH exit until the next LATCH; it is not cleared between instructions.
- EXEC:
  - stage increments by 1 per cycle from 2 to EXEC_STAGES+1.
  - If halt_for_keypress=1 and key_pressed=0 in any EXEC cycle → KEYWAIT with stage held.
  - If halt_for_keypress=1 and key_pressed=1 in the same cycle → no wait; stage advances normally.
- KEYWAIT:
  - stage frozen; the tick divider keeps running.
  - key_pressed=1 → back to EXEC with stage+1 on that edge.
  - run deasserted here does not leave KEYWAIT.
- Last execute stage (stage=EXEC_STAGES+1):
  - instr_done=1 for that cycle; instr_count+1 at the end of the cycle.
  - Next state is FETCH if run=1, else IDLE; stage returns to 0.
- run deasserted mid-instruction: the current instruction completes fully, then IDLE. run is sampled only at IDLE and at the last execute stage.
- Instruction period: 2+EXEC_STAGES cycles; 8 with defaults, keywait excluded.
- Timer divider:
  - Counts only when run=1 or state≠IDLE.
  - At count TICK_DIV-1: timer_tick=1 for one cycle, count → 0.
  - Holds its value when idle and stopped.
- Reset asserted mid-operation returns to reset values immediately. No fetch is issued until reset is deasserted and run=1.

Test Plan:
- Reset, run=1, PC_readdata=0x200, memory 0x200=0x61, 0x201=0xF0:
  - FETCH shows fetch_addr1=0x200, fetch_addr2=0x201, fetch_active=1.
  - instruction=0x61F0 from stage 2; stage runs 0..7.
  - instr_done pulses at stage 7; instr_count=1.
- PC_readdata=0xFFF → fetch_addr2=0x000; instruction={mem[0xFFF], mem[0x000]}.
- halt_for_keypress=1, key_pressed=0 at stage 3:
  - stage stays 3 for 10 cycles.
  - key_pressed=1 → stage 4 next cycle; instr_done arrives 10 cycles later than with no wait.
- halt_for_keypress=1 and key_pressed=1 at the same edge → no stall; period stays 8 cycles.
- Drop run at stage 4:
  - instruction completes through stage 7 with instr_done pulse, then IDLE, stage=0.
  - fetch_active stays 0 while idle.
- TICK_DIV=5, run=1:
  - timer_tick pulses on cycles 5, 10, 15.
  - Assert reset at cycle 12 → instr_count=0, stage=0, instruction=0x0000 asynchronously; next tick is 5 cycles after restart.
